// File: rtl/operand_entry_ctrl_pkg.sv
// operand_entry_ctrl_pkg: key codes, FSM state type and default range limit shared by the operand entry block
package operand_entry_ctrl_pkg;
    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;
    localparam int DEFAULT_MAX_MAG = 127;
    typedef enum logic [1:0] {ENTRY_A, ENTRY_B, READY, ERROR} state_t;
endpackage

// File: rtl/operand_entry_ctrl_if.sv
// operand_entry_ctrl_if: keypad/consumer bus of the operand entry block
//   key_valid/key_code/op_ack  : driven by the master (keypad + consumer)
//   operand_a/operand_b/op_ready/sel_b/err : driven by the slave (operand_entry_ctrl)
//   entry_bcd/entry_neg        : buffer echo, present only with ENTRY_ECHO_EN defined
interface operand_entry_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        op_ack;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic        op_ready;
    logic        sel_b;
    logic        err;
`ifdef ENTRY_ECHO_EN
    logic [11:0] entry_bcd;
    logic        entry_neg;
`endif
    modport master (
        output key_valid, key_code, op_ack,
        input  operand_a, operand_b, op_ready, sel_b, err
`ifdef ENTRY_ECHO_EN
        , input entry_bcd, entry_neg
`endif
    );
    modport slave (
        input  key_valid, key_code, op_ack,
        output operand_a, operand_b, op_ready, sel_b, err
`ifdef ENTRY_ECHO_EN
        , output entry_bcd, entry_neg
`endif
    );
endinterface

// File: rtl/operand_entry_ctrl_mag_calc.sv
// entry_mag_calc: BCD buffer to binary magnitude with range check
//   i_bcd  : three BCD digits, d2 in [11:8]
//   o_mag  : low 8 bits of d2*100 + d1*10 + d0
//   o_over : full magnitude exceeds MAX_MAG
module entry_mag_calc
    import operand_entry_ctrl_pkg::*;
#(
    parameter int MAX_MAG = DEFAULT_MAX_MAG
) (
    input  logic [11:0] i_bcd,
    output logic [7:0]  o_mag,
    output logic        o_over
);
    logic [9:0] w_mag;
    assign w_mag  = 10'(i_bcd[11:8]) * 10'd100 + 10'(i_bcd[7:4]) * 10'd10 + 10'(i_bcd[3:0]);
    assign o_mag  = w_mag[7:0];
    assign o_over = w_mag > 10'(MAX_MAG);
endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: keypad entry of two signed BCD operands with range check and ready/ack handoff
//   CLOCK, RESET : rising-edge clock, synchronous active-high reset
//   bus (slave)  : keys in, committed operands, op_ready, sel_b, err out
//   ENTRY_ECHO_EN: when defined, bus also carries entry_bcd/entry_neg echo of the pending entry
module operand_entry_ctrl
    import operand_entry_ctrl_pkg::*;
#(
    parameter int MAX_MAG    = DEFAULT_MAX_MAG,
    parameter int MAX_DIGITS = 3
) (
    input  logic CLOCK,
    input  logic RESET,
    operand_entry_ctrl_if.slave bus
);
    localparam logic [1:0] LP_MAXD = 2'(MAX_DIGITS);
    state_t      r_state, w_state;
    logic [11:0] r_bcd, w_bcd;
    logic [1:0]  r_cnt, w_cnt;
    logic        r_neg, w_neg;
    logic [7:0]  r_a, w_a, r_b, w_b;
    logic        r_ready, w_ready, r_selb, w_selb, r_err, w_err;
    logic [7:0]  w_mag, w_val;
    logic        w_over, w_digit;
    entry_mag_calc #(.MAX_MAG(MAX_MAG)) u_mag (
        .i_bcd (r_bcd),
        .o_mag (w_mag),
        .o_over(w_over)
    );
    assign w_val   = r_neg ? -w_mag : w_mag;
    assign w_digit = bus.key_code <= 4'd9;
    always_comb begin
        w_state = r_state;
        w_bcd   = r_bcd;
        w_cnt   = r_cnt;
        w_neg   = r_neg;
        w_a     = r_a;
        w_b     = r_b;
        w_ready = r_ready;
        w_selb  = r_selb;
        w_err   = r_err;
        unique case (r_state)
            ENTRY_A, ENTRY_B: begin
                if (bus.key_valid) begin
                    if (w_digit) begin
                        if (r_cnt < LP_MAXD) begin
                            w_bcd = {r_bcd[7:0], bus.key_code};
                            w_cnt = r_cnt + 2'd1;
                        end
                    end else if (bus.key_code == KEY_SIGN) begin
                        w_neg = ~r_neg;
                    end else if (bus.key_code == KEY_BKSP) begin
                        if (r_cnt != 2'd0) begin
                            w_bcd = {4'h0, r_bcd[11:4]};
                            w_cnt = r_cnt - 2'd1;
                        end
                    end else if (bus.key_code == KEY_CLR) begin
                        w_bcd = '0;
                        w_cnt = '0;
                        w_neg = 1'b0;
                    end else if (bus.key_code == KEY_ENTER && r_cnt != 2'd0) begin
                        if (w_over) begin
                            w_err   = 1'b1;
                            w_state = ERROR;
                        end else begin
                            w_bcd = '0;
                            w_cnt = '0;
                            w_neg = 1'b0;
                            if (r_state == ENTRY_A) begin
                                w_a     = w_val;
                                w_selb  = 1'b1;
                                w_state = ENTRY_B;
                            end else begin
                                w_b     = w_val;
                                w_ready = 1'b1;
                                w_state = READY;
                            end
                        end
                    end
                end
            end
            // sel_b still names the entry that failed, so it picks the return state
            ERROR: begin
                if (bus.key_valid && bus.key_code == KEY_CLR) begin
                    w_bcd   = '0;
                    w_cnt   = '0;
                    w_neg   = 1'b0;
                    w_err   = 1'b0;
                    w_state = r_selb ? ENTRY_B : ENTRY_A;
                end
            end
            READY: begin
                if (bus.op_ack) begin
                    w_ready = 1'b0;
                    w_selb  = 1'b0;
                    w_state = ENTRY_A;
                end
            end
            default: w_state = ENTRY_A;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ENTRY_A;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ready <= 1'b0;
            r_selb  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_bcd   <= w_bcd;
            r_cnt   <= w_cnt;
            r_neg   <= w_neg;
            r_a     <= w_a;
            r_b     <= w_b;
            r_ready <= w_ready;
            r_selb  <= w_selb;
            r_err   <= w_err;
        end
    end
    assign bus.operand_a = r_a;
    assign bus.operand_b = r_b;
    assign bus.op_ready  = r_ready;
    assign bus.sel_b     = r_selb;
    assign bus.err       = r_err;
`ifdef ENTRY_ECHO_EN
    assign bus.entry_bcd = r_bcd;
    assign bus.entry_neg = r_neg;
`endif
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: directed and random keypad stimulus checked against a digit-queue reference model
module tb_operand_entry_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    operand_entry_ctrl_if bus ();
    operand_entry_ctrl dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;

    int         dq[$];
    bit         m_neg, m_ready, m_err;
    int         m_phase;
    logic [7:0] m_a, m_b;

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic model_clear();
        dq.delete();
        m_neg = 1'b0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit ack, input bit r);
        int mag;
        if (r) begin
            model_clear();
            m_phase = 0; m_ready = 0; m_err = 0; m_a = 8'h00; m_b = 8'h00;
        end else if (m_ready) begin
            if (ack) begin m_ready = 0; m_phase = 0; end
        end else if (m_err) begin
            if (kv && kc == 12) begin m_err = 0; model_clear(); end
        end else if (kv) begin
            if (kc <= 9) begin
                if (dq.size() < 3) dq.push_back(kc);
            end else if (kc == 10) m_neg = !m_neg;
            else if (kc == 11) begin
                if (dq.size() > 0) void'(dq.pop_back());
            end else if (kc == 12) model_clear();
            else if (kc == 13 && dq.size() > 0) begin
                mag = 0;
                foreach (dq[i]) mag = mag * 10 + dq[i];
                if (mag > 127) m_err = 1;
                else begin
                    if (m_phase == 0) begin
                        m_a = m_neg ? 8'(-mag) : 8'(mag);
                        m_phase = 1;
                    end else begin
                        m_b = m_neg ? 8'(-mag) : 8'(mag);
                        m_ready = 1;
                    end
                    model_clear();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
`ifdef ENTRY_ECHO_EN
        logic [11:0] bcd;
`endif
        chk8({tag, " operand_a"}, bus.operand_a, m_a);
        chk8({tag, " operand_b"}, bus.operand_b, m_b);
        chk1({tag, " op_ready"}, bus.op_ready, m_ready);
        chk1({tag, " sel_b"}, bus.sel_b, m_phase == 1);
        chk1({tag, " err"}, bus.err, m_err);
`ifdef ENTRY_ECHO_EN
        bcd = '0;
        foreach (dq[i]) bcd = {bcd[7:0], 4'(dq[i])};
        n_vec++;
        assert (bus.entry_bcd === bcd) else begin
            n_err++;
            $error("FAIL %s entry_bcd: observed %h expected %h", tag, bus.entry_bcd, bcd);
        end
        chk1({tag, " entry_neg"}, bus.entry_neg, m_neg);
`endif
    endtask

    task automatic apply(input string tag, input bit kv, input int kc, input bit ack, input bit r);
        bus.key_valid = kv;
        bus.key_code  = 4'(kc);
        bus.op_ack    = ack;
        rst           = r;
        @(posedge clk);
        #1;
        model_step(kv, kc, ack, r);
        check_all(tag);
    endtask

    task automatic keys(input string tag, input int seq[$]);
        foreach (seq[i]) apply(tag, 1, seq[i], 0, 0);
    endtask

    initial begin
        bus.key_valid = 0;
        bus.key_code  = 0;
        bus.op_ack    = 0;
        #1;
        apply("reset", 0, 0, 0, 1);
        apply("reset", 1, 5, 1, 1);
        apply("idle", 0, 0, 0, 0);
        keys("r030", '{1, 2, 7, 13, 10, 4, 5, 13});
        chk8("r030 a", bus.operand_a, 8'h7F);
        chk8("r030 b", bus.operand_b, 8'hD3);
        chk1("r030 rdy", bus.op_ready, 1'b1);
        apply("r023 hold", 0, 0, 0, 0);
        apply("r033 ack", 1, 3, 1, 0);
        chk1("r033 rdy", bus.op_ready, 1'b0);
        chk1("r033 selb", bus.sel_b, 1'b0);
        chk8("r033 a", bus.operand_a, 8'h7F);
        keys("r031", '{1, 2, 8, 13});
        chk1("r031 err", bus.err, 1'b1);
        chk8("r031 a", bus.operand_a, 8'h7F);
        keys("r031 clr", '{5, 12});
        chk1("r031 err0", bus.err, 1'b0);
        chk1("r031 selb", bus.sel_b, 1'b0);
        keys("r032", '{9, 9, 9, 9, 11, 13});
        chk8("r032 a", bus.operand_a, 8'h63);
        apply("r024 ack", 0, 0, 1, 0);
        apply("rst2", 0, 0, 0, 1);
        keys("r034", '{10, 0, 13});
        chk8("r034 a", bus.operand_a, 8'h00);
        chk1("r034 selb", bus.sel_b, 1'b1);
        keys("r018", '{13, 13});
        keys("r035 pre", '{5, 14, 15});
        apply("r035 rst", 1, 13, 1, 1);
        chk1("r035 selb", bus.sel_b, 1'b0);
        for (int i = 0; i < 600; i++)
            apply("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 80) == 0);
        bus.key_valid = 0;
        bus.op_ack    = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
